// File: rtl/gate_slice_pipe.sv
// rtl/gate_slice_pipe.sv - pipelined per-slice two-input gate unit with valid/ready flow control
module gate_slice_pipe #(
    parameter int W     = 3,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     y,
    output logic [2:0]       y_op,
    output logic [CNT_W-1:0] txn_cnt
);
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_ZERO = 3'd6;

    logic             advance;
    logic [W-1:0]     raw;
    logic [W-1:0]     gate_res;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [W-1:0]     y_q  [DEPTH];
    logic [W-1:0]     y_d  [DEPTH];
    logic [2:0]       op_q [DEPTH];
    logic [2:0]       op_d [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The whole pipe moves together, so the only stall source is the last stage.
    assign advance  = !vld_q[DEPTH-1] || out_ready;
    assign in_ready = advance;

    always_comb begin
        case (op)
            OP_AND:  raw = a & b;
            OP_OR:   raw = a | b;
            OP_NOR:  raw = ~(a | b);
            OP_NAND: raw = ~(a & b);
            OP_XOR:  raw = a ^ b;
            OP_XNOR: raw = ~(a ^ b);
            OP_ZERO: raw = '0;
            default: raw = a;
        endcase
    end

    assign gate_res = raw & mask;

    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            y_d[i]  = y_q[i];
            op_d[i] = op_q[i];
        end
        if (advance) begin
            // Bubbles carry zero payload so an idle stage never shows stale data.
            vld_d[0] = in_valid;
            y_d[0]   = in_valid ? gate_res : '0;
            op_d[0]  = in_valid ? op : 3'd0;
            for (int i = 1; i < DEPTH; i++) begin
                vld_d[i] = vld_q[i-1];
                y_d[i]   = y_q[i-1];
                op_d[i]  = op_q[i-1];
            end
        end
    end

    assign cnt_d = (vld_q[DEPTH-1] && out_ready) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                y_q[i]  <= '0;
                op_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            y_q   <= y_d;
            op_q  <= op_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign y         = y_q[DEPTH-1];
    assign y_op      = op_q[DEPTH-1];
    assign txn_cnt   = cnt_q;

endmodule

// File: doc/gate_slice_pipe.md
# gate_slice_pipe

Parametrised, pipelined bitwise gate-slice unit for the ECO test suite: applies one of eight per-transaction selectable two-input gate functions across all W bit slices of `a` and `b`. Results travel through a DEPTH-stage register pipeline with valid/ready flow control and per-slice output masking. A wrapping transaction counter supports equivalence checks between pre- and post-ECO netlists.

## Interface
- `W`, default 3: slice count (operand/result width), ≥1.
- `DEPTH`, default 2: pipeline stages (latency), ≥1.
- `CNT_W`, default 8: width of transaction counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `in_valid`  in  1  input transaction valid.
- `in_ready`  out  1  unit can accept this cycle.
- `op`  in  3  gate function, sampled with the transaction.
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `mask`  in  W  per-slice enable; masked-off slices output 0.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `y`  out  W  result.
- `y_op`  out  3  op that produced `y`.
- `txn_cnt`  out  CNT_W  count of completed output transfers.

## Operation
- Accept: `in_valid && in_ready` at a rising edge. Complete: `out_valid && out_ready`.
- Per slice i: `y[i] = mask[i] ? f(op, a[i], b[i]) : 0`.
- op encoding: 0 AND, 1 OR, 2 NOR, 3 NAND, 4 XOR, 5 XNOR, 6 constant 0, 7 pass A.
- Function evaluated combinationally at stage 1 input; stages 1..DEPTH hold {valid, y, op}. No arithmetic; widths fixed at W.
- Pipeline stalls as a whole: advance = `!out_valid || out_ready`; `in_ready = advance`. When advance = 0, every stage holds contents and no input is accepted.
- Bubbles (stage valid = 0) propagate normally; no bubble compression.
- `txn_cnt` increments by 1 per completion, wraps from 2^CNT_W−1 to 0.
- Data/op of a held output stay stable while `out_valid && !out_ready`.

## Timing
- Reset (`rst_n` = 0 at a rising edge): all stage valid bits 0, all stage data 0, `y` = 0, `y_op` = 0, `out_valid` = 0, `txn_cnt` = 0. `in_ready` = 1 from the first cycle after reset (since `out_valid` = 0), including while `rst_n` is still low; transactions presented while `rst_n` = 0 are discarded.
- Reset mid-operation: all in-flight transactions dropped, no completion counted in the reset cycle.
- Latency: transaction accepted at edge k appears on `y`/`out_valid` after edge k+DEPTH−1 (i.e., visible in cycle k+DEPTH−1 window), provided no stall; each stall cycle adds one.
- Throughput: one transaction per cycle with `out_ready` held high.
- `in_ready` depends combinationally on `out_ready` (single-level ready path); `y`, `y_op`, `out_valid` are registered.
- Simultaneous completion and acceptance in the same cycle are both allowed; pipeline stays full.
- `txn_cnt` updates at the completion edge; visible next cycle.

## Test plan
- Reset/idle: hold `rst_n` = 0 two cycles with `in_valid` = 1 -> `out_valid` = 0, `y` = 0, `txn_cnt` = 0 throughout and after release.
- Function sweep (W=3, DEPTH=2, mask=111, out_ready=1): a=110, b=101, op 0..7 back-to-back -> y = 100, 111, 000, 011, 011, 100, 000, 110 in consecutive cycles starting one cycle after first accept; `y_op` tracks 0..7.
- Masking: op=1, a=111, b=000, mask=010 -> y = 010.
- Backpressure: stream 4 transactions, drop `out_ready` for 3 cycles after first result -> `in_ready` = 0 those cycles, held `y` stable, no loss/duplication, all 4 delivered in order, `txn_cnt` = 4.
- Counter wrap (CNT_W=2): 5 completions -> `txn_cnt` sequence 1,2,3,0,1.
- Reset mid-stream: reset with pipeline full -> next cycle `out_valid` = 0, `txn_cnt` = 0; a new transaction afterwards emerges after DEPTH cycles with correct result.
